// File: rtl/uart_delay_mc.sv
// uart_delay_mc: multi-channel serial-line delay. Each channel re-times the
// edges of its input onto its output a programmable number of clocks later,
// using a small per-channel queue of pending edges stamped against a shared
// free-running timebase.
module uart_delay_mc #(
    parameter int N_CH  = 4,
    parameter int DW    = 11,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH*DW-1:0] dv,
    input  logic [N_CH-1:0]    en,
    input  logic [N_CH-1:0]    txsdi,
    input  logic [N_CH-1:0]    ovf_clr,
    output logic [N_CH-1:0]    txsdo,
    output logic [N_CH-1:0]    busy,
    output logic [N_CH-1:0]    ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] t_q;

    // Shared timebase: free-running, wraps modulo 2^DW.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_q <= '0;
        end else begin
            t_q <= t_q + DW'(1'b1);
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic             s0_q, s1_q;
        logic             txsdo_q, txsdo_d;
        logic             busy_q;
        logic             ovf_q, ovf_d;
        logic [DW-1:0]    dvq_q, dvq_d;
        logic [DEPTH-1:0] lvl_q;
        logic [DW-1:0]    tgt_q [DEPTH];
        logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
        logic [AW:0]      cnt_q, cnt_d;
        logic             edge_s, empty_s, full_s, push_s, pop_s, ovfl_s, flush_s;
        logic [DW-1:0]    dv_eff_s;

        // Queue control: decide push/pop/overflow/flush and the next output level.
        always_comb begin
            edge_s   = s0_q ^ s1_q;
            empty_s  = (cnt_q == '0);
            full_s   = (cnt_q == (AW+1)'(DEPTH));
            dv_eff_s = (dvq_q == '0) ? DW'(1'b1) : dvq_q;
            pop_s    = en[c] && !empty_s && (t_q == tgt_q[rp_q]);
            push_s   = en[c] && edge_s;
            ovfl_s   = push_s && full_s && !pop_s;
            flush_s  = !en[c] || ovfl_s;
            txsdo_d  = txsdo_q;
            wp_d     = wp_q;
            rp_d     = rp_q;
            cnt_d    = cnt_q;
            if (flush_s) begin
                // Bypass or overflow: drop everything pending and follow s0.
                wp_d    = '0;
                rp_d    = '0;
                cnt_d   = '0;
                txsdo_d = s0_q;
            end else begin
                if (pop_s) begin
                    txsdo_d = lvl_q[rp_q];
                    rp_d    = rp_q + AW'(1'b1);
                end else begin
                    rp_d = rp_q;
                end
                if (push_s) begin
                    wp_d = wp_q + AW'(1'b1);
                end else begin
                    wp_d = wp_q;
                end
                cnt_d = cnt_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
            end
            // Delay only changes between bursts so queued targets stay ordered.
            if (empty_s && !edge_s) begin
                dvq_d = dv[c*DW +: DW];
            end else begin
                dvq_d = dvq_q;
            end
            // A coincident clear never wins over a fresh overflow.
            ovf_d = (ovf_q && !ovf_clr[c]) || ovfl_s;
        end

        // Channel state: input synchroniser, queue storage and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                s0_q    <= 1'b1;
                s1_q    <= 1'b1;
                txsdo_q <= 1'b1;
                busy_q  <= 1'b0;
                ovf_q   <= 1'b0;
                dvq_q   <= '0;
                wp_q    <= '0;
                rp_q    <= '0;
                cnt_q   <= '0;
                lvl_q   <= '1;
                for (int i = 0; i < DEPTH; i++) begin
                    tgt_q[i] <= '0;
                end
            end else begin
                s0_q    <= txsdi[c];
                s1_q    <= s0_q;
                txsdo_q <= txsdo_d;
                busy_q  <= (cnt_d != '0);
                ovf_q   <= ovf_d;
                dvq_q   <= dvq_d;
                wp_q    <= wp_d;
                rp_q    <= rp_d;
                cnt_q   <= cnt_d;
                if (push_s && !flush_s) begin
                    lvl_q[wp_q] <= s0_q;
                    tgt_q[wp_q] <= t_q + dv_eff_s;
                end
            end
        end

        assign txsdo[c] = txsdo_q;
        assign busy[c]  = busy_q;
        assign ovf[c]   = ovf_q;
    end

endmodule

// File: tb/tb_uart_delay_mc.sv
// Testbench for uart_delay_mc: directed scenarios plus randomized traffic,
// all compared against a queue-based model that schedules each edge at an
// absolute cycle number.
module tb_uart_delay_mc;

    localparam int N     = 4;
    localparam int DW    = 11;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*DW-1:0]  dv;
    logic [N-1:0]     en, txsdi, ovf_clr;
    logic [N-1:0]     txsdo, busy, ovf;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    longint     cyc = 0;
    logic [N-1:0] m_s0, m_s1, m_txsdo, m_busy, m_ovf;
    int         m_dvq [N];
    longint     qd [N][$];
    bit         ql [N][$];

    uart_delay_mc #(.N_CH(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .dv(dv), .en(en), .txsdi(txsdi),
        .ovf_clr(ovf_clr), .txsdo(txsdo), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        bit     edge_e, was_empty, pop, push, ov;
        int     eff;
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                m_s0[c] = 1'b1; m_s1[c] = 1'b1; m_txsdo[c] = 1'b1;
                m_busy[c] = 1'b0; m_ovf[c] = 1'b0; m_dvq[c] = 0;
                qd[c].delete(); ql[c].delete();
            end else begin
                edge_e    = (m_s0[c] != m_s1[c]);
                eff       = (m_dvq[c] == 0) ? 1 : m_dvq[c];
                was_empty = (qd[c].size() == 0);
                pop       = en[c] && !was_empty && (qd[c][0] == cyc);
                push      = en[c] && edge_e;
                ov        = push && (qd[c].size() == DEPTH) && !pop;
                if (!en[c] || ov) begin
                    qd[c].delete(); ql[c].delete();
                    m_txsdo[c] = m_s0[c];
                end else begin
                    if (pop) begin
                        m_txsdo[c] = ql[c].pop_front();
                        void'(qd[c].pop_front());
                    end
                    if (push) begin
                        qd[c].push_back(cyc + eff);
                        ql[c].push_back(m_s0[c]);
                    end
                end
                m_ovf[c] = (m_ovf[c] && !ovf_clr[c]) || ov;
                if (was_empty && !edge_e) m_dvq[c] = int'(dv[c*DW +: DW]);
                m_busy[c] = (qd[c].size() != 0);
                m_s1[c]   = m_s0[c];
                m_s0[c]   = txsdi[c];
            end
        end
        cyc++;
    endtask

    // One clock: model updates on the edge, outputs are settled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '1; dv = '0; txsdi = '1; ovf_clr = '0;
        cycle(); cycle();
        checks++;
        if (txsdo !== 4'hF) begin failures++; $display("FAIL reset_txsdo got=%b exp=1111", txsdo); end
        checks++;
        if (busy !== 4'h0) begin failures++; $display("FAIL reset_busy got=%b exp=0000", busy); end
        checks++;
        if (ovf !== 4'h0) begin failures++; $display("FAIL reset_ovf got=%b exp=0000", ovf); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (txsdo !== m_txsdo || busy !== m_busy || ovf !== m_ovf) begin
                failures++;
                $display("FAIL reset_model cyc=%0d txsdo=%b/%b busy=%b/%b ovf=%b/%b", cyc, txsdo, m_txsdo, busy, m_busy, ovf, m_ovf);
            end
        end
    endtask

    task automatic test_latency();
        int fall = -1, rise = -1, busy_bad = 0;
        for (int c = 0; c < N; c++) dv[c*DW +: DW] = 11'd10;
        for (int i = 0; i < 5; i++) cycle();
        txsdi[0] = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            cycle();
            if (j == 3) txsdi[0] = 1'b1;
            checks++;
            if (txsdo !== m_txsdo || busy !== m_busy || ovf !== m_ovf) begin
                failures++;
                $display("FAIL latency_model cyc=%0d txsdo=%b/%b busy=%b/%b ovf=%b/%b", cyc, txsdo, m_txsdo, busy, m_busy, ovf, m_ovf);
            end
            if (fall < 0 && txsdo[0] == 1'b0) fall = j;
            if (fall >= 0 && rise < 0 && txsdo[0] == 1'b1) rise = j;
            if (j >= 2 && j <= 14 && busy[0] !== 1'b1) busy_bad++;
        end
        checks++;
        if (fall != 12) begin failures++; $display("FAIL latency_fall got=%0d exp=12", fall); end
        checks++;
        if (rise - fall != 3) begin failures++; $display("FAIL latency_width got=%0d exp=3", rise - fall); end
        checks++;
        if (busy_bad != 0) begin failures++; $display("FAIL latency_busy got=%0d_low_cycles exp=0", busy_bad); end
    endtask

    task automatic test_min_delay();
        int lat;
        logic prev;
        for (int v = 0; v < 2; v++) begin
            dv[1*DW +: DW] = DW'(v);
            for (int i = 0; i < 8; i++) cycle();
            prev = txsdo[1];
            txsdi[1] = ~txsdi[1];
            lat = -1;
            for (int j = 1; j <= 10; j++) begin
                cycle();
                checks++;
                if (txsdo !== m_txsdo || busy !== m_busy || ovf !== m_ovf) begin
                    failures++;
                    $display("FAIL mindly_model cyc=%0d txsdo=%b/%b busy=%b/%b ovf=%b/%b", cyc, txsdo, m_txsdo, busy, m_busy, ovf, m_ovf);
                end
                if (lat < 0 && txsdo[1] !== prev) lat = j;
            end
            checks++;
            if (lat != 3) begin failures++; $display("FAIL mindly_dv%0d got=%0d exp=3", v, lat); end
        end
        txsdi[1] = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
    endtask

    task automatic test_overflow();
        dv[2*DW +: DW] = 11'd50;
        dv[0]          = 1'b0;
        dv[0*DW +: DW] = 11'd8;
        for (int i = 0; i < 20; i++) cycle();
        // ch2: five edges two clocks apart against a long delay
        for (int e = 0; e < 5; e++) begin
            txsdi[2] = ~txsdi[2];
            for (int k = 0; k < 2; k++) begin
                cycle();
                checks++;
                if (txsdo !== m_txsdo || busy !== m_busy || ovf !== m_ovf) begin
                    failures++;
                    $display("FAIL ovf_model cyc=%0d txsdo=%b/%b busy=%b/%b ovf=%b/%b", cyc, txsdo, m_txsdo, busy, m_busy, ovf, m_ovf);
                end
            end
        end
        checks++;
        if (ovf[2] !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf[2]); end
        checks++;
        if (busy[2] !== 1'b0) begin failures++; $display("FAIL ovf_flush got=%b exp=0", busy[2]); end
        checks++;
        if (txsdo[2] !== 1'b0) begin failures++; $display("FAIL ovf_txsdo got=%b exp=0", txsdo[2]); end
        for (int i = 0; i < 4; i++) cycle();
        checks++;
        if (ovf[2] !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf[2]); end
        ovf_clr[2] = 1'b1;
        cycle();
        ovf_clr[2] = 1'b0;
        checks++;
        if (ovf[2] !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf[2]); end
        txsdi[2] = 1'b1;
        // ch0: full queue with simultaneous push and pop must not overflow
        for (int e = 0; e < 6; e++) begin
            txsdi[0] = ~txsdi[0];
            for (int k = 0; k < 2; k++) begin
                cycle();
                checks++;
                if (txsdo !== m_txsdo || busy !== m_busy || ovf !== m_ovf) begin
                    failures++;
                    $display("FAIL pushpop_model cyc=%0d txsdo=%b/%b busy=%b/%b ovf=%b/%b", cyc, txsdo, m_txsdo, busy, m_busy, ovf, m_ovf);
                end
            end
        end
        checks++;
        if (ovf[0] !== 1'b0) begin failures++; $display("FAIL pushpop_noovf got=%b exp=0", ovf[0]); end
        for (int i = 0; i < 70; i++) cycle();
    endtask

    task automatic test_wrap();
        int t1 = -1, t2 = -1;
        logic prev;
        dv[3*DW +: DW] = 11'd2047;
        for (int i = 0; i < 4; i++) cycle();
        prev = txsdo[3];
        txsdi[3] = 1'b0;
        for (int j = 1; j <= 2070; j++) begin
            cycle();
            if (j == 5) txsdi[3] = 1'b1;
            checks++;
            if (txsdo !== m_txsdo || busy !== m_busy || ovf !== m_ovf) begin
                failures++;
                $display("FAIL wrap_model cyc=%0d txsdo=%b/%b busy=%b/%b ovf=%b/%b", cyc, txsdo, m_txsdo, busy, m_busy, ovf, m_ovf);
            end
            if (txsdo[3] !== prev) begin
                if (t1 < 0) t1 = j; else if (t2 < 0) t2 = j;
                prev = txsdo[3];
            end
        end
        checks++;
        if (t1 != 2049) begin failures++; $display("FAIL wrap_first got=%0d exp=2049", t1); end
        checks++;
        if (t2 - t1 != 5) begin failures++; $display("FAIL wrap_spacing got=%0d exp=5", t2 - t1); end
    endtask

    task automatic test_dv_change();
        int   times [3];
        int   n = 0, lat = -1;
        logic prev;
        dv[1*DW +: DW] = 11'd20;
        for (int i = 0; i < 25; i++) cycle();
        prev = txsdo[1];
        txsdi[1] = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            cycle();
            if (j == 3) begin txsdi[1] = 1'b1; dv[1*DW +: DW] = 11'd5; end
            if (j == 6) txsdi[1] = 1'b0;
            checks++;
            if (txsdo !== m_txsdo || busy !== m_busy || ovf !== m_ovf) begin
                failures++;
                $display("FAIL dvchg_model cyc=%0d txsdo=%b/%b busy=%b/%b ovf=%b/%b", cyc, txsdo, m_txsdo, busy, m_busy, ovf, m_ovf);
            end
            if (txsdo[1] !== prev) begin
                if (n < 3) times[n] = j;
                n++;
                prev = txsdo[1];
            end
        end
        checks++;
        if (n != 3 || times[0] != 22 || times[1] != 25 || times[2] != 28) begin
            failures++;
            $display("FAIL dvchg_burst got=n%0d:%0d,%0d,%0d exp=n3:22,25,28", n, times[0], times[1], times[2]);
        end
        txsdi[1] = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            cycle();
            if (lat < 0 && txsdo[1] !== prev) lat = j;
        end
        checks++;
        if (lat != 7) begin failures++; $display("FAIL dvchg_next got=%0d exp=7", lat); end
    endtask

    task automatic test_bypass_reset();
        int   lat = -1;
        logic prev;
        en[0] = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        prev = txsdo[0];
        txsdi[0] = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            cycle();
            if (lat < 0 && txsdo[0] !== prev) lat = j;
        end
        checks++;
        if (lat != 2) begin failures++; $display("FAIL bypass_lat got=%0d exp=2", lat); end
        en[0] = 1'b1;
        dv[0*DW +: DW] = 11'd10;
        for (int j = 1; j <= 30; j++) begin
            if (j % 3 == 0) txsdi[0] = ~txsdi[0];
            if (j == 10) en[0] = 1'b0;
            if (j == 14) en[0] = 1'b1;
            cycle();
            checks++;
            if (txsdo !== m_txsdo || busy !== m_busy || ovf !== m_ovf) begin
                failures++;
                $display("FAIL entog_model cyc=%0d txsdo=%b/%b busy=%b/%b ovf=%b/%b", cyc, txsdo, m_txsdo, busy, m_busy, ovf, m_ovf);
            end
        end
        checks++;
        if (busy[0] !== 1'b1) begin failures++; $display("FAIL rst_pending got=%b exp=1", busy[0]); end
        rst = 1'b1;
        cycle();
        checks++;
        if (txsdo !== 4'hF || busy !== 4'h0) begin
            failures++;
            $display("FAIL rst_mid got=txsdo%b_busy%b exp=txsdo1111_busy0000", txsdo, busy);
        end
        rst = 1'b0;
        txsdi = '1;
        for (int i = 0; i < 4; i++) cycle();
    endtask

    task automatic test_random();
        for (int j = 0; j < 3000; j++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 5) == 0) txsdi[c] = ~txsdi[c];
                if ($urandom_range(0, 60) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 30) == 0) dv[c*DW +: DW] = DW'($urandom_range(0, 12));
                ovf_clr[c] = ($urandom_range(0, 40) == 0);
            end
            rst = ($urandom_range(0, 999) == 0);
            cycle();
            checks++;
            if (txsdo !== m_txsdo || busy !== m_busy || ovf !== m_ovf) begin
                failures++;
                $display("FAIL random_model cyc=%0d txsdo=%b/%b busy=%b/%b ovf=%b/%b", cyc, txsdo, m_txsdo, busy, m_busy, ovf, m_ovf);
            end
        end
        rst = 1'b0;
        ovf_clr = '0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_min_delay();
        test_overflow();
        test_wrap();
        test_dv_change();
        test_bypass_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_delay_mc.md
UART_DELAY_MC -- requirements
Module: uart_delay_mc

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, number of independent serial channels.
REQ-002 The block SHALL have parameter DW, default 11, delay value and timebase width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4, a power of 2 ≥2, giving pending-edge queue entries per channel.
REQ-004 clk  input  1  the only clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 dv  input  N_CH*DW  per-channel delay in clocks; channel c uses bits [c*DW +: DW].
REQ-007 en  input  N_CH  per-channel delay enable; 0 selects bypass.
REQ-008 txsdi  input  N_CH  serial inputs, idle high.
REQ-009 ovf_clr  input  N_CH  per-channel overflow-flag clear pulse.
REQ-010 txsdo  output  N_CH  delayed serial outputs, registered.
REQ-011 busy  output  N_CH  1 while the channel queue is non-empty, registered.
REQ-012 ovf  output  N_CH  sticky per-channel queue-overflow flag, registered.

Function
REQ-013 Each channel SHALL register txsdi into s0, then s0 into s1; an edge event SHALL be s0 != s1.
REQ-014 A shared free-running DW-bit timebase T SHALL increment every clock and wrap modulo 2^DW.
REQ-015 Each channel SHALL hold a latched delay dv_q, loaded from its dv slice only in a cycle when its queue is empty and no edge event occurs; dv changes at other times SHALL be deferred.
REQ-016 Effective delay SHALL be dv_eff = max(dv_q, 1).
REQ-017 On an edge event with en=1, the channel SHALL push {level=s0, target=(T+dv_eff) mod 2^DW} into its FIFO queue.
REQ-018 When the queue is non-empty and T equals the head target, txsdo SHALL load head.level on the next edge and the head SHALL be popped.
REQ-019 Latency: a txsdi change first sampled into s0 at clock k SHALL appear on txsdo at clock k+dv_eff+1; pulse widths and edge spacing SHALL be preserved exactly while no overflow occurs.
REQ-020 Push and pop in the same cycle SHALL both take effect; with the queue full, this SHALL NOT count as overflow.
REQ-021 A push into a full queue without a simultaneous pop SHALL be an overflow: set ovf, flush the queue, and load txsdo with s0 on the same edge.
REQ-022 ovf SHALL stay set until an ovf_clr pulse; if overflow and ovf_clr coincide, ovf SHALL end set.
REQ-023 With en=0, txsdo SHALL load s0 every clock, the queue SHALL be flushed, and no push or overflow SHALL occur.
REQ-024 On an en 1->0 transition, pending edges SHALL be discarded; on an en 0->1 transition, queueing SHALL begin with the next edge event.
REQ-025 busy SHALL equal queue non-empty after each edge.
REQ-026 Channels SHALL be fully independent except for sharing T.

Reset
REQ-027 With rst high at a clock edge, s0, s1 and txsdo SHALL be all-ones, busy and ovf all-zeros, T=0, dv_q=0, and all queues empty.
REQ-028 Reset SHALL override all other activity, including mid-delay, and pending edges SHALL be lost.

Verification
REQ-029 dv=10, en=1, low pulse 3 clocks on ch0 -> txsdo[0] low pulse of exactly 3 clocks starting 11 clocks after s0 falls; busy[0] set throughout.
REQ-030 dv=0 and dv=1 -> identical latency of 2 clocks from s0 change to txsdo change.
REQ-031 DEPTH=4, dv=50, 5 edges 2 clocks apart -> 5th edge sets ovf, queue flushes, txsdo=s0; ovf_clr then clears ovf.
REQ-032 dv=2047 with edges spanning a T wrap -> correct timing across the wrap.
REQ-033 Change dv from 20 to 5 mid-burst -> remaining edges keep delay 20; the next burst after the queue empties uses 5.
REQ-034 rst asserted with edges pending, and en toggled mid-burst -> txsdo=1 and busy=0 after reset; bypass makes txsdo track s0 with 1 clock delay.
